// File: rtl/pe_operand_sequencer.sv
// rtl/pe_operand_sequencer.sv - operand buffer and issue sequencer feeding one processing element
//
// Buffers a dot-product job of up to DEPTH (x, w) operand pairs, issues them
// to the PE one pair at a time, and returns the PE's final partial_sum on a
// valid/ready result port. No arithmetic is done here; the PE accumulates.
//
// Ports:
//   clk, n_rst          clock, synchronous active-low reset
//   op_wr_en/addr/x/w   operand buffer write port (accepted only while idle)
//   start, len          job launch and pair count (0..DEPTH, larger is clamped)
//   busy                high whenever a job is in flight or a result is pending
//   pe_x, pe_w          operand pair to the PE, held while waiting on it
//   pe_input_start      one-cycle pulse per issued pair
//   pe_stall            PE cannot accept a new pair
//   pe_data_ready       PE partial_sum is valid this cycle
//   pe_partial_sum      PE running sum
//   result/result_err   final sum and timeout-abort flag
//   result_valid/ready  result handshake

module pe_operand_sequencer #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     op_wr_en,
    input  logic [$clog2(DEPTH)-1:0] op_wr_addr,
    input  logic [DATA_W-1:0]        op_x,
    input  logic [DATA_W-1:0]        op_w,
    input  logic                     start,
    input  logic [$clog2(DEPTH):0]   len,
    output logic                     busy,
    output logic [DATA_W-1:0]        pe_x,
    output logic [DATA_W-1:0]        pe_w,
    output logic                     pe_input_start,
    input  logic                     pe_stall,
    input  logic                     pe_data_ready,
    input  logic [DATA_W-1:0]        pe_partial_sum,
    output logic [DATA_W-1:0]        result,
    output logic                     result_err,
    output logic                     result_valid,
    input  logic                     result_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [LW-1:0] DEPTH_LEN  = LW'(DEPTH);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t state_q, state_d;

    logic [AW-1:0]     idx_q, idx_d;
    logic [LW-1:0]     len_q, len_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [TW-1:0]     timer_q, timer_d;

    logic [DATA_W-1:0] pe_x_q, pe_x_d;
    logic [DATA_W-1:0] pe_w_q, pe_w_d;
    logic              pe_start_q, pe_start_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              err_q, err_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;

    logic [DATA_W-1:0] buf_x_q [DEPTH];
    logic [DATA_W-1:0] buf_w_q [DEPTH];

    logic [LW-1:0] len_eff;
    logic          last_pair;

    // Buffer contents survive reset. A write issued in the same cycle as start
    // lands before the first ISSUE cycle reads it, so the job always sees it.
    always_ff @(posedge clk) begin
        if (op_wr_en && (state_q == ST_IDLE) && ({1'b0, op_wr_addr} < DEPTH_LEN)) begin
            buf_x_q[op_wr_addr] <= op_x;
            buf_w_q[op_wr_addr] <= op_w;
        end
    end

    assign len_eff   = (len > DEPTH_LEN) ? DEPTH_LEN : len;
    assign last_pair = ({1'b0, idx_q} == (len_q - LW'(1)));

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            len_q      <= '0;
            acc_q      <= '0;
            timer_q    <= '0;
            pe_x_q     <= '0;
            pe_w_q     <= '0;
            pe_start_q <= 1'b0;
            result_q   <= '0;
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            acc_q      <= acc_d;
            timer_q    <= timer_d;
            pe_x_q     <= pe_x_d;
            pe_w_q     <= pe_w_d;
            pe_start_q <= pe_start_d;
            result_q   <= result_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        acc_d      = acc_q;
        timer_d    = timer_q;
        pe_x_d     = pe_x_q;
        pe_w_d     = pe_w_q;
        pe_start_d = 1'b0;
        result_d   = result_q;
        err_d      = err_q;
        valid_d    = valid_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d = '0;
                    if (len_eff == '0) begin
                        // Empty job: report a zero sum straight away.
                        result_d = '0;
                        err_d    = 1'b0;
                        valid_d  = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        len_d   = len_eff;
                        idx_d   = '0;
                        state_d = ST_ISSUE;
                    end
                end
            end

            ST_ISSUE: begin
                if (!pe_stall) begin
                    pe_start_d = 1'b1;
                    pe_x_d     = buf_x_q[idx_q];
                    pe_w_d     = buf_w_q[idx_q];
                    timer_d    = '0;
                    state_d    = ST_WAIT;
                end
            end

            ST_WAIT: begin
                // data_ready is checked first so it wins over a same-cycle timeout.
                if (pe_data_ready) begin
                    acc_d = pe_partial_sum;
                    if (last_pair) begin
                        result_d = pe_partial_sum;
                        err_d    = 1'b0;
                        valid_d  = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = ST_ISSUE;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    // Abort: report whatever partial sum was last captured.
                    result_d = acc_q;
                    err_d    = 1'b1;
                    valid_d  = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            ST_DONE: begin
                if (result_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_d = (state_d != ST_IDLE);

    assign busy           = busy_q;
    assign pe_x           = pe_x_q;
    assign pe_w           = pe_w_q;
    assign pe_input_start = pe_start_q;
    assign result         = result_q;
    assign result_err     = err_q;
    assign result_valid   = valid_q;

endmodule

// File: doc/pe_operand_sequencer.md
Name: pe_operand_sequencer

Overview:
- Upstream driver for one processing element: buffers a dot-product job of up to DEPTH operand pairs (x, w).
- Issues the pairs to the PE one at a time, obeying the PE's stall/input_start/data_ready protocol.
- Captures the final partial_sum and presents it on a valid/ready result port.
- Sits between the array load controller and a single PE; the array top instantiates one per row or column edge.

Parameters:
- DATA_W, 32, operand/result width (word_t width).
- DEPTH, 8, operand buffer entries; maximum job length.
- TIMEOUT, 64, maximum cycles spent waiting for pe_data_ready per pair before aborting.

Ports:
- clk  in  1  clock.
- n_rst  in  1  synchronous active-low reset.
- op_wr_en  in  1  write strobe for the operand buffer.
- op_wr_addr  in  $clog2(DEPTH)  buffer index.
- op_x  in  DATA_W  x operand to write.
- op_w  in  DATA_W  w operand to write.
- start  in  1  launch a job (sampled only in IDLE).
- len  in  $clog2(DEPTH)+1  number of pairs, 0..DEPTH.
- busy  out  1  high in every state except IDLE.
- pe_x  out  DATA_W  to PE x_i.
- pe_w  out  DATA_W  to PE w_i.
- pe_input_start  out  1  to PE input_start.
- pe_stall  in  1  from PE stall.
- pe_data_ready  in  1  from PE data_ready.
- pe_partial_sum  in  DATA_W  from PE partial_sum.
- result  out  DATA_W  final partial sum.
- result_err  out  1  job aborted by timeout.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts result.

Behaviour:
- Reset is synchronous: on a clk edge with n_rst=0, all outputs go to 0, state=IDLE, idx=0, acc=0, timer=0. Buffer contents are not reset. Reset mid-job aborts the job silently; no result is produced.
- All outputs are registered.
- Buffer writes:
  - Accepted only in IDLE.
  - Writes while busy are dropped.
  - op_wr_en together with start in the same cycle: the write lands first and is visible to the job.
- IDLE:
  - start=1 and len in 1..DEPTH: latch len, idx=0, acc=0 -> ISSUE.
  - start=1 and len=0: acc=0, result_err=0 -> DONE.
  - len>DEPTH is clamped to DEPTH.
- ISSUE:
  - pe_stall=1: hold; pe_input_start stays 0.
  - pe_stall=0: next cycle pe_input_start=1 for exactly one cycle, pe_x=buf_x[idx], pe_w=buf_w[idx], timer=0 -> WAIT.
- WAIT:
  - pe_x/pe_w are held stable and pe_input_start=0; timer increments each cycle.
  - pe_data_ready=1: acc<=pe_partial_sum.
    - If idx==len-1 -> DONE with result_err=0.
    - Otherwise idx++ -> ISSUE.
  - timer reaches TIMEOUT-1 with no pe_data_ready -> DONE with result_err=1; acc holds the last captured value.
  - pe_data_ready and timeout in the same cycle: data_ready wins.
  - pe_data_ready outside WAIT is ignored.
- DONE:
  - result=acc and result_valid=1, both held.
  - result_ready=1: result_valid drops next cycle -> IDLE.
  - result_ready=1 on the first DONE cycle is legal, giving a one-cycle valid.
  - start during DONE is ignored.
- Minimum per-pair cost is 2 cycles plus PE latency.
- The PE's internal accumulation makes the last partial_sum the full dot product; the sequencer performs no arithmetic.

Test Plan:
- Write x=[1.0,2.0,3.0] (0x3F800000, 0x40000000, 0x40400000) and w=[4.0,5.0,6.0]; start len=3 with a behavioural PE (latency 3) -> exactly 3 one-cycle input_start pulses; result=0x42000000 (32.0), result_err=0.
- Same job with pe_stall held high 5 cycles in ISSUE -> no input_start while stalled; pulse on the first cycle after stall drops; result unchanged.
- start with len=0 -> result_valid=1 two cycles later, result=0, no input_start pulses.
- PE model never raises data_ready, TIMEOUT=64 -> result_valid with result_err=1 about 64 cycles after the pulse; busy stays high until result_ready.
- result_ready held low 10 cycles in DONE; also op_wr_en and start pulsed -> result stable; buffer unchanged on a rerun; no new job starts.
- n_rst=0 for one cycle during WAIT of pair 2 -> next cycle all outputs 0, state IDLE; a subsequent fresh job completes correctly.
